// File: rtl/clock_buff.sv
// -----------------------------------------------------------------------------
// clock_buff
//
// Purpose:
//   Buffered, reset-gated copy of the master clock. While rst is high, bclk is
//   held low. After rst is released, an enable chain clocked on the mclk
//   falling edge counts SYNC_STAGES falling edges and then raises gate_en.
//   From then on bclk = mclk with identical period, duty cycle and edge
//   timing. gate_en only changes while mclk is low, so bclk never carries a
//   truncated pulse. The one exception is an asynchronous reset assertion
//   during the mclk high phase.
//
// Parameters:
//   SYNC_STAGES : number of mclk falling edges from reset release to enable
//                 (legal range 1..4, default 2).
//
// Ports (declaration order is fixed so that a positional (mclk, bclk)
// instantiation binds correctly):
//   mclk : in  master clock, the only clock in this block
//   bclk : out buffered mclk, low while in reset or not yet enabled
//   rst  : in  asynchronous active-high reset; must always be driven
// -----------------------------------------------------------------------------
module clock_buff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic mclk,
  output logic bclk,
  input  logic rst
);

  // Enable chain: stage 0 samples a constant 1, and each later stage samples
  // the stage before it. gate_en is the last stage.
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   gate_en;

  // NOTE: every variable in a combinational block gets a default value before
  // any conditional code. Otherwise an unassigned path infers a latch.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = 1'b1;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // The chain is clocked on the falling edge, so gate_en can only change while
  // mclk is low. Reset clears the chain immediately. A release that coincides
  // with a falling edge is not counted, because that edge still samples rst
  // high.
  // NOTE: sequential state uses non-blocking assignments, so all flops sampled
  // on the same edge see pre-edge values.
  always_ff @(negedge mclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign gate_en = sync_q[SYNC_STAGES-1];

  // Output gate. rst is also included in the condition. When rst is unknown,
  // the if condition is not true, so bclk keeps its low default. An asserted
  // rst therefore forces bclk low in the same timestep, whatever the chain
  // holds.
  always_comb begin
    bclk = 1'b0;
    if (rst == 1'b0) begin
      bclk = mclk & gate_en;
    end
  end

endmodule

// File: tb/tb_clock_buff.sv
// -----------------------------------------------------------------------------
// tb_clock_buff
//
// Directed bench for clock_buff. One instance uses SYNC_STAGES=2 and a second
// uses SYNC_STAGES=1. Both share one mclk (10 ns period, low at t=0, first
// rising edge at 5 ns). The bench records edge timestamps of each bclk and
// compares them with hand-computed times. It also samples levels at fixed
// points in the mclk high and low phases.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clock_buff;

  logic mclk;
  logic clk_run = 1'b1;
  logic rst2;
  logic rst1;
  logic bclk2;
  logic bclk1;

  int n_checks = 0;
  int n_pass   = 0;

  longint b2_rise[$];
  longint b2_fall[$];
  longint b1_rise[$];
  longint b1_fall[$];

  clock_buff #(.SYNC_STAGES(2)) u_dut2 (.mclk(mclk), .bclk(bclk2), .rst(rst2));
  clock_buff #(.SYNC_STAGES(1)) u_dut1 (.mclk(mclk), .bclk(bclk1), .rst(rst1));

  // mclk: low at 0, toggles every 5 ns while clk_run is set.
  initial begin
    mclk = 1'b0;
    forever begin
      #5;
      if (clk_run) mclk = ~mclk;
    end
  end

  always @(posedge bclk2) b2_rise.push_back(longint'($time));
  always @(negedge bclk2) b2_fall.push_back(longint'($time));
  always @(posedge bclk1) b1_rise.push_back(longint'($time));
  always @(negedge bclk1) b1_fall.push_back(longint'($time));

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic wait_until(input longint t);
    if (longint'($time) < t) #(t - longint'($time));
  endtask

  // Returns the first entry at or after time t, or -1 if there is none.
  function automatic longint first_at_or_after(input longint q[$], input longint t);
    foreach (q[i]) if (q[i] >= t) return q[i];
    return -1;
  endfunction

  // Returns the index of the entry equal to t, or -1 if there is none.
  function automatic int index_of(input longint q[$], input longint t);
    foreach (q[i]) if (q[i] == t) return i;
    return -1;
  endfunction

  initial begin
    int     i0;
    int     j0;
    int     bad;
    longint min_hi;
    longint min_lo;

    // The first reset assertion happens at 1 ns.
    rst2 = 1'b0;
    rst1 = 1'b0;
    wait_until(1);
    rst2 = 1'b1;
    rst1 = 1'b1;

    // While in reset, bclk stays low even during the mclk high phases.
    wait_until(7);
    check("rst_bclk2_hi7", bclk2, 0);
    check("rst_bclk1_hi7", bclk1, 0);
    wait_until(17);
    check("rst_bclk2_hi17", bclk2, 0);
    check("rst_bclk1_hi17", bclk1, 0);

    // Reset release at 23 ns. The 1-stage chain enables at 30 and the
    // 2-stage chain enables at 40.
    wait_until(23);
    rst2 = 1'b0;
    rst1 = 1'b0;
    wait_until(29);
    check("gate1_before30", u_dut1.gate_en, 0);
    wait_until(31);
    check("gate1_after30", u_dut1.gate_en, 1);
    wait_until(37);
    check("bclk1_hi37", bclk1, 1);
    check("bclk2_hi37", bclk2, 0);
    wait_until(39);
    check("gate2_before40", u_dut2.gate_en, 0);
    wait_until(41);
    check("gate2_after40", u_dut2.gate_en, 1);
    wait_until(47);
    check("bclk2_hi47", bclk2, 1);

    // Reset asserted at 57 ns, during the mclk high phase, and released at 83.
    wait_until(57);
    rst2 = 1'b1;
    wait_until(58);
    check("bclk2_rst58", bclk2, 0);
    check("gate2_rst58", u_dut2.gate_en, 0);
    wait_until(67);
    check("bclk2_rst67", bclk2, 0);
    wait_until(83);
    rst2 = 1'b0;
    wait_until(87);
    check("bclk2_wait87", bclk2, 0);
    wait_until(97);
    check("bclk2_wait97", bclk2, 0);
    wait_until(107);
    check("bclk2_hi107", bclk2, 1);

    check("b2_first_rise", first_at_or_after(b2_rise, 0), 45);
    check("b2_second_rise", first_at_or_after(b2_rise, 46), 55);
    check("b2_fall_on_rst", first_at_or_after(b2_fall, 56), 57);
    check("b2_rise_after_83", first_at_or_after(b2_rise, 83), 105);
    check("b1_first_rise", first_at_or_after(b1_rise, 0), 35);

    // Reset released exactly on the 230 ns falling edge. The release is
    // scheduled after that edge has sampled rst, so the edge counts as not
    // seen. The edges at 240 and 250 enable bclk, so the first rise is at 255.
    wait_until(201);
    rst2 = 1'b1;
    wait_until(230);
    rst2 <= 1'b0;
    wait_until(237);
    check("bclk2_coinc237", bclk2, 0);
    wait_until(247);
    check("bclk2_coinc247", bclk2, 0);
    wait_until(257);
    check("bclk2_coinc257", bclk2, 1);
    check("b2_rise_after_230", first_at_or_after(b2_rise, 230), 255);

    // Stop mclk during a high phase and check that both bclks freeze high.
    wait_until(1267);
    clk_run = 1'b0;
    wait_until(1300);
    check("mclk_frozen", mclk, 1);
    check("bclk2_frozen", bclk2, 1);
    check("bclk1_frozen", bclk1, 1);

    // Duty and phase over 100 cycles from 255 ns. Each rise must be at
    // 255+10k and each fall at 260+10k, matching mclk exactly.
    i0  = index_of(b2_rise, 255);
    j0  = index_of(b2_fall, 260);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (i0 < 0 || i0 + k >= b2_rise.size()) bad++;
      else if (b2_rise[i0+k] != 255 + 10*k) bad++;
      if (j0 < 0 || j0 + k >= b2_fall.size()) bad++;
      else if (b2_fall[j0+k] != 260 + 10*k) bad++;
    end
    check("b2_duty_bad_edges", bad, 0);

    // The 1-stage instance has no glitch. Every high and low pulse after the
    // first rise is 5 ns wide.
    min_hi = 1000;
    min_lo = 1000;
    for (int k = 0; k < b1_rise.size() && k < b1_fall.size(); k++) begin
      if (b1_fall[k] - b1_rise[k] < min_hi) min_hi = b1_fall[k] - b1_rise[k];
      if (k + 1 < b1_rise.size() && b1_rise[k+1] - b1_fall[k] < min_lo)
        min_lo = b1_rise[k+1] - b1_fall[k];
    end
    check("b1_min_high", min_hi, 5);
    check("b1_min_low", min_lo, 5);
    check("b1_rise_count", b1_rise.size(), 124);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_buff.md
CLOCK_BUFF -- requirements
Module: clock_buff

Interface
REQ-001 Parameter SYNC_STAGES, default 2, legal range 1-4: number of mclk falling edges between reset release and bclk enable.
REQ-002 mclk  input  1  master clock, the only clock in the block.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 bclk  output  1  buffered copy of mclk, gated low while reset or not yet enabled.
REQ-005 Port declaration order SHALL be mclk, bclk, rst, so a positional two-port instantiation (mclk, bclk) binds correctly; rst SHALL always be driven by the integrator.

Function
REQ-006 Block SHALL contain an enable chain of SYNC_STAGES flops clocked on mclk falling edge; stage 0 input tied high; last stage output = gate_en.
REQ-007 bclk SHALL equal mclk AND gate_en, with gate_en only able to change while mclk is low, so bclk never carries a truncated or glitch pulse except as stated in REQ-011.
REQ-008 Steady state (gate_en=1): bclk period SHALL equal mclk period, duty cycle identical, zero frequency difference.
REQ-009 Steady state: every bclk edge SHALL occur in the same simulation timestep as the corresponding mclk edge; zero-delay RTL, no #delays, no inversion, no division.
REQ-010 After rst deasserts, gate_en SHALL rise on the SYNC_STAGES-th mclk falling edge; first bclk rising edge SHALL coincide with the next mclk rising edge.
REQ-011 rst assertion at any time, including mid mclk-high phase, SHALL clear the chain and force bclk low in the same timestep.
REQ-012 rst deassertion coincident with an mclk falling edge SHALL count that edge as not seen; counting starts at the following falling edge.
REQ-013 Once gate_en=1 it SHALL remain 1 until the next rst assertion; mclk stopping SHALL freeze bclk at mclk's level.
REQ-014 X/Z on rst SHALL be treated as asserted at simulation (bclk held 0); no latches other than the chain flops.

Reset
REQ-015 During rst=1: all chain stages 0, gate_en 0, bclk 0, regardless of mclk activity.
REQ-016 Reset SHALL be asynchronous on assertion; release is synchronized to mclk falling edge by the chain.
REQ-017 No power-on state is relied upon; behaviour before the first rst assertion is undefined and not verified.

Verification (mclk period 10 ns, starts 0, first rising edge at 5 ns, SYNC_STAGES=2)
REQ-018 rst=1 for 0-23 ns -> bclk 0 throughout; falling edges at 30 and 40 ns -> gate_en=1 at 40 ns; first bclk rising edge at 45 ns.
REQ-019 After enable, measure two consecutive rising edges of mclk and bclk in parallel -> period difference 0, phase difference 0 (same timestamps, e.g. 55/65 ns both).
REQ-020 Duty check: bclk high 5 ns, low 5 ns per cycle, matching mclk for 100 cycles.
REQ-021 rst asserted at 57 ns (mclk high) -> bclk falls at 57 ns; stays 0 while rst=1; release at 83 ns -> falling edges 90, 100 ns -> next bclk rising edge at 105 ns.
REQ-022 rst released at exactly 30 ns (falling edge) -> edges 40 and 50 ns counted -> first bclk rising edge at 55 ns.
REQ-023 SYNC_STAGES=1, rst released at 23 ns -> gate_en at 30 ns -> first bclk rising edge at 35 ns; no bclk pulse narrower than 5 ns at any point.
